seq_001_stream_ctrl: RTL and testbench
======================================

Name: seq_001_stream_ctrl

Overview:
- Controller that sequences a "001" Moore detector over framed parallel words.
- Accepts WORD_W-bit words through a valid/ready handshake and serialises each word MSB-first into a clock-enabled 001 detector.
- Counts detections across word boundaries within a frame.
- Reports the per-frame match count through a valid/ready result port; sits between a byte-stream source and a status/CSR consumer.

Parameters:
- WORD_W, 8: bits per input word, shifted out MSB first.
- CNT_W, 16: width of the frame match counter (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_data  input  WORD_W  input word.
- in_last  input  1  word is the last of its frame; sampled with in_data.
- in_ready  output  1  controller can accept a word.
- out_valid  output  1  frame result valid.
- out_count  output  CNT_W  number of "001" detections in the frame.
- out_sat  output  1  counter saturated during the frame.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- One clock, clk. Reset is synchronous and active-high (reset).
- Reset values: state IDLE, shift register 0, bit index 0, last flag 0, count 0, sat 0, step_d 0, detector state s0, out_valid 0.
- in_ready = (state==IDLE) && !reset.
- FSM states and transitions:
  - IDLE: on in_valid && in_ready, load in_data into the shift register and latch in_last. Go to SHIFT with bit index WORD_W-1.
  - SHIFT: bit_en=1; serial bit = shift register MSB; shift left one bit and decrement the index each cycle. After WORD_W cycles, go to FLUSH if the last flag is set, else go to IDLE.
  - FLUSH: one cycle with bit_en=0. Lets the detector output for the final bit be counted.
  - REPORT: out_valid=1 with out_count/out_sat held stable. On out_ready, clear count, sat and detector state to s0 at that edge, then go to IDLE.
- Detector (sub-module):
  - State s0..s3 advances only when bit_en=1; transitions are those of the 001 Moore machine.
  - det = (state==s3), Moore output.
  - clear input forces s0 with priority over bit_en.
- Counting:
  - step_d <= bit_en every cycle.
  - count increments when step_d && det. This counts each enabled step once, regardless of idle gaps between words (no double count while the detector holds s3).
- Saturation: at count == all-ones, further hits hold the value and set sat.
- Detector state and count persist across words of a frame. Patterns spanning a word boundary are counted.
- Latency:
  - Handshake in cycle 0; bits in cycles 1..WORD_W.
  - For a last word: FLUSH in cycle WORD_W+1, out_valid from cycle WORD_W+2.
  - Throughput: one word per WORD_W+1 cycles when in_valid is held.
- Boundaries:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored unless out_valid.
  - A single-word frame is valid.
  - Zero matches report count 0.
  - Reset asserted in any state aborts the frame: returns to IDLE, drops the partial count, produces no out_valid.

Decomposition:
- Shared package holds:
  - detector state encodings S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11;
  - controller state encodings IDLE, SHIFT, FLUSH, REPORT.
- One sub-module: seq_001_det_en. It is the clock-enabled, clearable 001 Moore detector with ports clk, reset, clear, bit_en, bit_in, det.
- Shift/count/FSM logic lives in the top.

Test Plan:
- Single word 0x24 (00100100), in_last=1 -> out_valid at cycle 10 after handshake, out_count=2, out_sat=0.
- Words 0x00 then 0x80 (last) -> boundary-spanning match, out_count=1.
- Word 0x01 (last) -> match on final bit, captured in FLUSH, out_count=1.
- Word 0x00, in_valid low 5 cycles, then 0x80 (last) -> out_count=1 (no gap double count); in_ready high throughout the gap.
- Backpressure and saturation, each one check:
  - out_ready low 4 cycles -> out_valid/out_count stable; accepted on the out_ready cycle; in_ready returns the next cycle with count cleared.
  - CNT_W=2, frame 0x24,0x24 (last) -> 4 hits, out_count=3, out_sat=1.
- Reset mid-SHIFT of word 0x24 -> no out_valid; next frame 0x01 (last) reports out_count=1, proving the detector and count were cleared.

Source files
------------

// File: rtl/seq_001_stream_ctrl_pkg.sv
// Shared encodings for the framed "001" stream controller and its detector.
package seq_001_stream_ctrl_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } det_state_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FLUSH,
      REPORT
   } ctrl_state_t;

   // S1 = seen "0", S2 = seen "00", S3 = seen "001"
   function automatic det_state_t det_next(input det_state_t s, input logic b);
      det_state_t n;
      n = S0;
      case (s)
         S0: n = b ? S0 : S1;
         S1: n = b ? S0 : S2;
         S2: n = b ? S3 : S2;
         S3: n = b ? S0 : S1;
         default: n = S0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/seq_001_det_en.sv
// Clock-enabled, clearable "001" Moore detector; clear wins over bit_en.
module seq_001_det_en
   import seq_001_stream_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic bit_en,
   input  logic bit_in,
   output logic det
);

   det_state_t state;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state <= S0;
      end else if (bit_en) begin
         state <= det_next(state, bit_in);
      end
   end

   assign det = (state == S3);

endmodule

// File: rtl/seq_001_stream_ctrl.sv
// Serialises framed words MSB-first into a 001 detector and reports the
// saturating per-frame match count over a valid/ready result port.
module seq_001_stream_ctrl
   import seq_001_stream_ctrl_pkg::*;
#(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              out_valid,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_sat,
   input  logic              out_ready
);

   localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   ctrl_state_t       state;
   logic [WORD_W-1:0] shreg;
   logic [IDX_W-1:0]  idx;
   logic              last_flag;
   logic [CNT_W-1:0]  count;
   logic              sat;
   logic              step_d;
   logic              bit_en;
   logic              det;
   logic              det_clear;

   assign bit_en    = (state == SHIFT);
   assign det_clear = out_valid && out_ready;
   assign in_ready  = (state == IDLE) && !reset;
   assign out_count = count;
   assign out_sat   = sat;

   seq_001_det_en u_det (
      .clk    (clk),
      .reset  (reset),
      .clear  (det_clear),
      .bit_en (bit_en),
      .bit_in (shreg[WORD_W-1]),
      .det    (det)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shreg     <= '0;
         idx       <= '0;
         last_flag <= 1'b0;
         count     <= '0;
         sat       <= 1'b0;
         step_d    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         step_d <= bit_en;
         // det lags its enabled step by one cycle; step_d qualifies it so a
         // held S3 during idle gaps is counted exactly once
         if (step_d && det) begin
            if (count == '1) begin
               sat <= 1'b1;
            end else begin
               count <= count + 1'b1;
            end
         end
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg     <= in_data;
                  last_flag <= in_last;
                  idx       <= IDX_W'(WORD_W - 1);
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               shreg <= shreg << 1;
               idx   <= idx - 1'b1;
               if (idx == '0) begin
                  state <= last_flag ? FLUSH : IDLE;
               end
            end
            FLUSH: begin
               out_valid <= 1'b1;
               state     <= REPORT;
            end
            REPORT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  count     <= '0;
                  sat       <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_001_stream_ctrl.sv
// Bench for seq_001_stream_ctrl: a 16-bit and a 2-bit counter instance share stimulus.
module tb_seq_001_stream_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_ready;
   logic        in_ready, out_valid, out_sat;
   logic [15:0] out_count;
   logic        s_in_ready, s_out_valid, s_out_sat;
   logic [1:0]  s_out_count;

   int unsigned total  = 0;
   int unsigned passed = 0;

   always #5 clk = ~clk;

   seq_001_stream_ctrl #(.WORD_W(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
      .out_count(out_count), .out_sat(out_sat), .out_ready(out_ready)
   );

   seq_001_stream_ctrl #(.WORD_W(8), .CNT_W(2)) dut_small (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(s_in_ready), .out_valid(s_out_valid),
      .out_count(s_out_count), .out_sat(s_out_sat), .out_ready(out_ready)
   );

   typedef struct packed {
      logic [2:0]      nw;
      logic [3:0][7:0] w;
      logic [3:0]      gap;
      logic [15:0]     exp_cnt;
   } vec_t;

   function automatic vec_t mk(input int unsigned nw, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d,
                               input int unsigned gap, input int unsigned exp_cnt);
      vec_t v;
      v.nw = 3'(nw);
      v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
      v.gap = 4'(gap);
      v.exp_cnt = 16'(exp_cnt);
      return v;
   endfunction

   // Count every "001" in the frame's MSB-first bit string
   function automatic int unsigned model_count(input logic [7:0] ws[$]);
      logic bits[$];
      int unsigned n = 0;
      foreach (ws[i]) begin
         for (int b = 7; b >= 0; b--) bits.push_back(ws[i][b]);
      end
      for (int i = 2; i < bits.size(); i++) begin
         if (!bits[i-2] && !bits[i-1] && bits[i]) n++;
      end
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      total++;
      $display("FAIL %s: timed out waiting on DUT", name);
   endtask

   task automatic wait_ready(input string name);
      int unsigned n = 0;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) timeout(name);
   endtask

   task automatic send_word(input logic [7:0] d, input logic l);
      wait_ready("in_ready");
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_result(input string tag, input int unsigned exp_cnt, input int unsigned hold);
      int unsigned n = 0;
      int unsigned exp_small;
      exp_small = (exp_cnt > 3) ? 3 : exp_cnt;
      while (!out_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         timeout({tag, "_out_valid"});
      end else begin
         check({tag, "_cnt"}, 32'(out_count), exp_cnt);
         check({tag, "_sat"}, 32'(out_sat), 0);
         check({tag, "_small_cnt"}, 32'(s_out_count), exp_small);
         check({tag, "_small_sat"}, 32'(s_out_sat), (exp_cnt > 3) ? 1 : 0);
      end
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic run_frame(input string tag, input logic [7:0] ws[$], input int unsigned gap,
                            input int unsigned hold, input int unsigned exp_cnt);
      for (int i = 0; i < ws.size(); i++) begin
         if (gap > 0) begin
            wait_ready({tag, "_pre_gap"});
            for (int g = 0; g < int'(gap); g++) begin
               check($sformatf("%s_gap_ready%0d", tag, g), 32'(in_ready), 1);
               @(negedge clk);
            end
         end
         send_word(ws[i], (i == ws.size() - 1));
      end
      wait_result(tag, exp_cnt, hold);
   endtask

   initial begin
      vec_t        vecs[8];
      logic [7:0]  q[$];
      logic [15:0] cap;
      logic        stable;
      logic        seen;

      vecs[0] = mk(1, 8'h24, 8'h00, 8'h00, 8'h00, 0, 2);
      vecs[1] = mk(2, 8'h00, 8'h80, 8'h00, 8'h00, 0, 1);
      vecs[2] = mk(1, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1);
      vecs[3] = mk(2, 8'h00, 8'h80, 8'h00, 8'h00, 5, 1);
      vecs[4] = mk(1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0);
      vecs[5] = mk(2, 8'h24, 8'h24, 8'h00, 8'h00, 0, 4);
      vecs[6] = mk(1, 8'h92, 8'h00, 8'h00, 8'h00, 1, 2);
      vecs[7] = mk(4, 8'h00, 8'h00, 8'h00, 8'h01, 0, 1);

      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_small_ready", 32'(s_in_ready), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_count", 32'(out_count), 0);
      check("rst_out_sat", 32'(out_sat), 0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 1);
      check("post_rst_small_ready", 32'(s_in_ready), 1);

      // Result must appear exactly 10 cycles after the handshake cycle
      send_word(8'h24, 1'b1);
      repeat (8) @(negedge clk);
      check("lat_cycle9_valid", 32'(out_valid), 0);
      @(negedge clk);
      check("lat_cycle10_valid", 32'(out_valid), 1);
      wait_result("lat", 2, 0);

      for (int i = 0; i < 8; i++) begin
         q.delete();
         for (int j = 0; j < int'(vecs[i].nw); j++) q.push_back(vecs[i].w[j]);
         run_frame($sformatf("tbl%0d", i), q, int'(vecs[i].gap), 0, int'(vecs[i].exp_cnt));
      end

      send_word(8'h24, 1'b1);
      begin
         int unsigned n = 0;
         while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
         end
      end
      if (!out_valid) begin
         timeout("bp_out_valid");
      end else begin
         cap = out_count;
         stable = 1'b1;
         repeat (4) begin
            @(negedge clk);
            if (!out_valid || out_count !== cap) stable = 1'b0;
         end
         check("bp_stable", 32'(stable), 1);
         check("bp_cnt", 32'(out_count), 2);
         out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready = 1'b0;
         check("bp_valid_dropped", 32'(out_valid), 0);
         check("bp_in_ready", 32'(in_ready), 1);
         check("bp_cnt_cleared", 32'(out_count), 0);
      end

      // Reset after the first hit of 0x24 has been counted
      send_word(8'h24, 1'b1);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         if (out_valid) seen = 1'b1;
         @(negedge clk);
      end
      check("rstmid_no_valid", 32'(seen), 0);
      check("rstmid_in_ready", 32'(in_ready), 1);
      q.delete();
      q.push_back(8'h01);
      run_frame("rstmid_next", q, 0, 0, 1);

      for (int f = 0; f < 25; f++) begin
         int unsigned nw;
         nw = $urandom_range(1, 4);
         q.delete();
         for (int j = 0; j < int'(nw); j++) begin
            q.push_back(8'($urandom_range(0, 255) & $urandom_range(0, 255)));
         end
         run_frame($sformatf("rnd%0d", f), q, $urandom_range(0, 2), $urandom_range(0, 3),
                   model_count(q));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
